// File: rtl/multicycle_datapath.sv
// Multicycle RISC-V style datapath: PC/instruction/data registers, 32x32 register file, ALU and muxes.
// Architectural state updates on rising clk; all outputs are combinational from state and control inputs.
module multicycle_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  ImmSrc,
    input  logic [1:0]  ALUSrcA,
    input  logic [1:0]  ALUSrcB,
    input  logic [1:0]  ResultSrc,
    input  logic        AdrSrc,
    input  logic [2:0]  ALUControl,
    input  logic        IRWrite,
    input  logic        PCWrite,
    input  logic        RegWrite,
    input  logic [31:0] ReadData,
    output logic [31:0] Adr,
    output logic [31:0] WriteData,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic        Zero
);

    logic [31:0] r_pc, r_old_pc, r_instr, r_data, r_a, r_b, r_alu_out;
    logic [31:0] r_rf [32];

    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [31:0] w_rd1, w_rd2, w_imm_ext;
    logic [31:0] w_src_a, w_src_b, w_alu_result, w_result;

    assign w_rs1 = r_instr[19:15];
    assign w_rs2 = r_instr[24:20];
    assign w_rd  = r_instr[11:7];

    // Reads see pre-edge contents, so a same-cycle write reaches A/B one edge later.
    assign w_rd1 = (w_rs1 == 5'd0) ? 32'h0 : r_rf[w_rs1];
    assign w_rd2 = (w_rs2 == 5'd0) ? 32'h0 : r_rf[w_rs2];

    always_comb begin
        w_imm_ext = 32'h0;
        case (ImmSrc)
            2'b00: w_imm_ext = {{20{r_instr[31]}}, r_instr[31:20]};
            2'b01: w_imm_ext = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
            2'b10: w_imm_ext = {{19{r_instr[31]}}, r_instr[31], r_instr[7],
                                r_instr[30:25], r_instr[11:8], 1'b0};
            2'b11: w_imm_ext = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12],
                                r_instr[20], r_instr[30:21], 1'b0};
            default: w_imm_ext = 32'h0;
        endcase
    end

    always_comb begin
        w_src_a = 32'h0;
        case (ALUSrcA)
            2'b00:   w_src_a = r_pc;
            2'b01:   w_src_a = r_old_pc;
            2'b10:   w_src_a = r_a;
            default: w_src_a = 32'h0;
        endcase
    end

    always_comb begin
        w_src_b = 32'h0;
        case (ALUSrcB)
            2'b00:   w_src_b = r_b;
            2'b01:   w_src_b = w_imm_ext;
            2'b10:   w_src_b = 32'd4;
            default: w_src_b = 32'h0;
        endcase
    end

    always_comb begin
        w_alu_result = 32'h0;
        case (ALUControl)
            3'b000:  w_alu_result = w_src_a + w_src_b;
            3'b001:  w_alu_result = w_src_a + ~w_src_b + 32'd1;
            3'b010:  w_alu_result = w_src_a & w_src_b;
            3'b011:  w_alu_result = w_src_a | w_src_b;
            3'b101:  w_alu_result = {31'h0, $signed(w_src_a) < $signed(w_src_b)};
            default: w_alu_result = 32'h0;
        endcase
    end

    always_comb begin
        w_result = 32'h0;
        case (ResultSrc)
            2'b00:   w_result = r_alu_out;
            2'b01:   w_result = r_data;
            2'b10:   w_result = w_alu_result;
            default: w_result = 32'h0;
        endcase
    end

    assign Adr       = AdrSrc ? w_result : r_pc;
    assign WriteData = r_b;
    assign op        = r_instr[6:0];
    assign funct3    = r_instr[14:12];
    assign funct7b5  = r_instr[30];
    assign Zero      = (w_alu_result == 32'h0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_old_pc  <= 32'h0;
            r_instr   <= 32'h0;
            r_data    <= 32'h0;
            r_a       <= 32'h0;
            r_b       <= 32'h0;
            r_alu_out <= 32'h0;
        end else begin
            if (PCWrite) r_pc <= w_result;
            // OldPC takes the pre-edge PC even when PC is also being updated.
            if (IRWrite) begin
                r_old_pc <= r_pc;
                r_instr  <= ReadData;
            end
            r_data    <= ReadData;
            r_a       <= w_rd1;
            r_b       <= w_rd2;
            r_alu_out <= w_alu_result;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_rf[i] <= 32'h0;
        end else if (RegWrite && (w_rd != 5'd0)) begin
            r_rf[w_rd] <= w_result;
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: reset, fetch, addi flow, immediates, x0 writes, ALU ops.
module tb_multicycle_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
    logic        AdrSrc;
    logic [2:0]  ALUControl;
    logic        IRWrite, PCWrite, RegWrite;
    logic [31:0] ReadData;
    logic [31:0] Adr, WriteData;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5, Zero;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_datapath #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .ALUControl(ALUControl), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ReadData(ReadData), .Adr(Adr),
        .WriteData(WriteData), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ImmSrc = 2'b00; ALUSrcA = 2'b00; ALUSrcB = 2'b00; ResultSrc = 2'b00;
        AdrSrc = 1'b0; ALUControl = 3'b000;
        IRWrite = 1'b0; PCWrite = 1'b0; RegWrite = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] instr, input logic adv);
        idle();
        ReadData = instr; IRWrite = 1'b1; PCWrite = adv;
        ALUSrcA = 2'b00; ALUSrcB = 2'b10; ALUControl = 3'b000; ResultSrc = 2'b10;
        tick();
        IRWrite = 1'b0; PCWrite = 1'b0;
    endtask

    task automatic write_reg(input logic [4:0] rd, input logic [31:0] val);
        fetch({12'h0, 5'h0, 3'h0, rd, 7'h13}, 1'b0);
        ReadData = val;
        tick();
        ResultSrc = 2'b01; RegWrite = 1'b1;
        tick();
        RegWrite = 1'b0;
    endtask

    task automatic load_ab(input logic [4:0] rs1, input logic [4:0] rs2);
        fetch({7'h0, rs2, rs1, 3'h0, 5'h0, 7'h33}, 1'b0);
        tick();
    endtask

    // Route ALUResult onto Adr for observation.
    task automatic view_alu(input logic [1:0] a_sel, input logic [1:0] b_sel, input logic [2:0] ctl);
        ALUSrcA = a_sel; ALUSrcB = b_sel; ALUControl = ctl; ResultSrc = 2'b10; AdrSrc = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1; ReadData = 32'hDEAD_BEEF;
        #2;
        n_checks++; if (Adr !== 32'h0) begin n_fail++; $display("FAIL reset_adr: got %h expected %h", Adr, 32'h0); end
        n_checks++; if (op !== 7'h00) begin n_fail++; $display("FAIL reset_op: got %h expected %h", op, 7'h00); end
        n_checks++; if (funct3 !== 3'h0 || funct7b5 !== 1'b0) begin n_fail++; $display("FAIL reset_funct: got %h/%b expected 0/0", funct3, funct7b5); end
        n_checks++; if (WriteData !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected %h", WriteData, 32'h0); end
        // Enables active while reset holds must not move state.
        IRWrite = 1'b1; PCWrite = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        tick(); tick();
        idle();
        #1;
        n_checks++; if (Adr !== 32'h0) begin n_fail++; $display("FAIL reset_hold_adr: got %h expected %h", Adr, 32'h0); end
        n_checks++; if (op !== 7'h00) begin n_fail++; $display("FAIL reset_hold_op: got %h expected %h", op, 7'h00); end
        #2;
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        fetch(32'h0050_0093, 1'b1);
        idle(); #1;
        n_checks++; if (Adr !== 32'h4) begin n_fail++; $display("FAIL fetch_pc: got %h expected %h", Adr, 32'h4); end
        n_checks++; if (op !== 7'b0010011) begin n_fail++; $display("FAIL fetch_op: got %b expected %b", op, 7'b0010011); end
        n_checks++; if (funct3 !== 3'b000) begin n_fail++; $display("FAIL fetch_funct3: got %b expected %b", funct3, 3'b000); end
        view_alu(2'b01, 2'b11, 3'b000);
        n_checks++; if (Adr !== 32'h0) begin n_fail++; $display("FAIL fetch_oldpc: got %h expected %h", Adr, 32'h0); end
    endtask

    task automatic test_addi();
        idle();
        tick();
        ImmSrc = 2'b00;
        view_alu(2'b10, 2'b01, 3'b000);
        n_checks++; if (Adr !== 32'h5) begin n_fail++; $display("FAIL addi_aluresult: got %h expected %h", Adr, 32'h5); end
        tick();
        ResultSrc = 2'b00; #1;
        n_checks++; if (Adr !== 32'h5) begin n_fail++; $display("FAIL addi_aluout: got %h expected %h", Adr, 32'h5); end
        RegWrite = 1'b1;
        tick();
        RegWrite = 1'b0;
        fetch(32'h0010_0023, 1'b1);
        idle(); #1;
        n_checks++; if (WriteData !== 32'h0) begin n_fail++; $display("FAIL addi_wdata_early: got %h expected %h", WriteData, 32'h0); end
        n_checks++; if (op !== 7'b0100011) begin n_fail++; $display("FAIL store_op: got %b expected %b", op, 7'b0100011); end
        n_checks++; if (Adr !== 32'h8) begin n_fail++; $display("FAIL fetch2_pc: got %h expected %h", Adr, 32'h8); end
        tick();
        n_checks++; if (WriteData !== 32'h5) begin n_fail++; $display("FAIL addi_wdata: got %h expected %h", WriteData, 32'h5); end
        view_alu(2'b01, 2'b11, 3'b000);
        n_checks++; if (Adr !== 32'h4) begin n_fail++; $display("FAIL fetch2_oldpc: got %h expected %h", Adr, 32'h4); end
    endtask

    task automatic test_same_cycle();
        fetch(32'h0010_00B3, 1'b0);
        tick();
        ReadData = 32'h77;
        tick();
        ResultSrc = 2'b01; RegWrite = 1'b1;
        tick();
        RegWrite = 1'b0;
        n_checks++; if (WriteData !== 32'h5) begin n_fail++; $display("FAIL rw_same_old: got %h expected %h", WriteData, 32'h5); end
        tick();
        n_checks++; if (WriteData !== 32'h77) begin n_fail++; $display("FAIL rw_same_new: got %h expected %h", WriteData, 32'h77); end
    endtask

    task automatic test_x0_write();
        fetch(32'h0000_0013, 1'b0);
        ReadData = 32'h1234;
        tick();
        ResultSrc = 2'b01; AdrSrc = 1'b1; RegWrite = 1'b1; #1;
        n_checks++; if (Adr !== 32'h1234) begin n_fail++; $display("FAIL x0_result: got %h expected %h", Adr, 32'h1234); end
        tick();
        RegWrite = 1'b0;
        tick();
        view_alu(2'b10, 2'b11, 3'b000);
        n_checks++; if (Adr !== 32'h0) begin n_fail++; $display("FAIL x0_read: got %h expected %h", Adr, 32'h0); end
    endtask

    task automatic test_immediate();
        fetch(32'hFFF0_0093, 1'b0);
        tick();
        ImmSrc = 2'b00; view_alu(2'b10, 2'b01, 3'b000);
        n_checks++; if (Adr !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL imm_i: got %h expected %h", Adr, 32'hFFFF_FFFF); end
        ImmSrc = 2'b01; #1;
        n_checks++; if (Adr !== 32'hFFFF_FFE1) begin n_fail++; $display("FAIL imm_s: got %h expected %h", Adr, 32'hFFFF_FFE1); end
        ImmSrc = 2'b10; #1;
        n_checks++; if (Adr !== 32'hFFFF_FFE0) begin n_fail++; $display("FAIL imm_b: got %h expected %h", Adr, 32'hFFFF_FFE0); end
        ImmSrc = 2'b11; #1;
        n_checks++; if (Adr !== 32'hFFF0_0FFE) begin n_fail++; $display("FAIL imm_j: got %h expected %h", Adr, 32'hFFF0_0FFE); end
    endtask

    task automatic test_alu();
        write_reg(5'd2, 32'h7);
        write_reg(5'd3, 32'hFFFF_FFFF);
        write_reg(5'd4, 32'h1);
        load_ab(5'd2, 5'd2);
        view_alu(2'b10, 2'b00, 3'b001);
        n_checks++; if (Zero !== 1'b1 || Adr !== 32'h0) begin n_fail++; $display("FAIL alu_sub_eq: got zero=%b res=%h expected zero=1 res=0", Zero, Adr); end
        view_alu(2'b10, 2'b00, 3'b000);
        n_checks++; if (Zero !== 1'b0 || Adr !== 32'hE) begin n_fail++; $display("FAIL alu_add: got zero=%b res=%h expected zero=0 res=e", Zero, Adr); end
        load_ab(5'd3, 5'd4);
        view_alu(2'b10, 2'b00, 3'b101);
        n_checks++; if (Adr !== 32'h1 || Zero !== 1'b0) begin n_fail++; $display("FAIL alu_slt_neg: got res=%h zero=%b expected res=1 zero=0", Adr, Zero); end
        view_alu(2'b10, 2'b00, 3'b001);
        n_checks++; if (Adr !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL alu_sub_wrap: got %h expected %h", Adr, 32'hFFFF_FFFE); end
        view_alu(2'b10, 2'b00, 3'b010);
        n_checks++; if (Adr !== 32'h1) begin n_fail++; $display("FAIL alu_and: got %h expected %h", Adr, 32'h1); end
        view_alu(2'b10, 2'b00, 3'b011);
        n_checks++; if (Adr !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL alu_or: got %h expected %h", Adr, 32'hFFFF_FFFF); end
        view_alu(2'b10, 2'b00, 3'b100);
        n_checks++; if (Adr !== 32'h0 || Zero !== 1'b1) begin n_fail++; $display("FAIL alu_code4: got res=%h zero=%b expected res=0 zero=1", Adr, Zero); end
        view_alu(2'b10, 2'b00, 3'b111);
        n_checks++; if (Adr !== 32'h0) begin n_fail++; $display("FAIL alu_code7: got %h expected %h", Adr, 32'h0); end
        view_alu(2'b11, 2'b10, 3'b000);
        n_checks++; if (Adr !== 32'h4) begin n_fail++; $display("FAIL alu_zero_plus4: got %h expected %h", Adr, 32'h4); end
        ResultSrc = 2'b11; #1;
        n_checks++; if (Adr !== 32'h0) begin n_fail++; $display("FAIL result_zero_sel: got %h expected %h", Adr, 32'h0); end
        load_ab(5'd4, 5'd3);
        view_alu(2'b10, 2'b00, 3'b101);
        n_checks++; if (Adr !== 32'h0 || Zero !== 1'b1) begin n_fail++; $display("FAIL alu_slt_pos: got res=%h zero=%b expected res=0 zero=1", Adr, Zero); end
        view_alu(2'b10, 2'b00, 3'b001);
        n_checks++; if (Adr !== 32'h2) begin n_fail++; $display("FAIL alu_sub_neg: got %h expected %h", Adr, 32'h2); end
    endtask

    task automatic test_reset_mid();
        idle();
        IRWrite = 1'b1; PCWrite = 1'b1; ReadData = 32'h0010_00B3;
        ALUSrcB = 2'b10; ResultSrc = 2'b10;
        #2;
        reset = 1'b1;
        AdrSrc = 1'b0; #1;
        n_checks++; if (Adr !== 32'h0) begin n_fail++; $display("FAIL mid_reset_pc: got %h expected %h", Adr, 32'h0); end
        n_checks++; if (WriteData !== 32'h0 || op !== 7'h0) begin n_fail++; $display("FAIL mid_reset_state: got wd=%h op=%h expected 0/0", WriteData, op); end
        idle();
        #2;
        reset = 1'b0;
        load_ab(5'd1, 5'd1);
        n_checks++; if (WriteData !== 32'h0) begin n_fail++; $display("FAIL mid_reset_rf: got %h expected %h", WriteData, 32'h0); end
        fetch(32'h0050_0093, 1'b1);
        idle(); #1;
        n_checks++; if (Adr !== 32'h4) begin n_fail++; $display("FAIL post_reset_fetch: got %h expected %h", Adr, 32'h4); end
    endtask

    initial begin
        reset = 1'b1;
        ReadData = 32'h0;
        idle();
        test_reset();
        test_fetch();
        test_addi();
        test_same_cycle();
        test_x0_write();
        test_immediate();
        test_alu();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_datapath.md
MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk  in  1  rising-edge clock for all state elements.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 ImmSrc  in  2  immediate format: 00 I, 01 S, 10 B, 11 J.
REQ-005 ALUSrcA  in  2  SrcA select: 00 PC, 01 OldPC, 10 A, 11 zero.
REQ-006 ALUSrcB  in  2  SrcB select: 00 B, 01 ImmExt, 10 constant 4, 11 zero.
REQ-007 ResultSrc  in  2  Result select: 00 ALUOut, 01 Data, 10 ALUResult, 11 zero.
REQ-008 AdrSrc  in  1  memory address select: 0 PC, 1 Result.
REQ-009 ALUControl  in  3  000 add, 001 sub, 010 and, 011 or, 101 signed slt; other codes give result 0.
REQ-010 IRWrite, PCWrite, RegWrite  in  1 each  enables for Instr/OldPC, PC and register file.
REQ-011 ReadData  in  32  memory read data.
REQ-012 Adr  out  32  memory address.
REQ-013 WriteData  out  32  store data, equal to register B.
REQ-014 op  out  7  Instr[6:0]; funct3 out 3 Instr[14:12]; funct7b5 out 1 Instr[30].
REQ-015 Zero  out  1  high when ALUResult == 0.

Function
REQ-016 State elements: PC, OldPC, Instr, Data, A, B, ALUOut (32 bits each), register file 32x32.
REQ-017 PC SHALL load Result on a clk edge when PCWrite=1, else hold.
REQ-018 OldPC and Instr SHALL load PC and ReadData on a clk edge when IRWrite=1, else hold.
REQ-019 Data, A, B and ALUOut SHALL load ReadData, RD1, RD2 and ALUResult on every clk edge.
REQ-020 Register-file reads SHALL be combinational: RD1 from rs1=Instr[19:15], RD2 from rs2=Instr[24:20]; x0 reads 0.
REQ-021 Register-file writes SHALL occur on a clk edge when RegWrite=1 and rd=Instr[11:7] != 0; Result is the write data; rd=0 writes are discarded.
REQ-022 On a same-cycle read and write of one register, RD SHALL return the old value; A/B capture the new value one edge later.
REQ-023 ImmExt SHALL be sign-extended from Instr[31]. I: Instr[31:20]. S: {Instr[31:25],Instr[11:7]}. B: {Instr[31],Instr[7],Instr[30:25],Instr[11:8],0}. J: {Instr[31],Instr[19:12],Instr[20],Instr[30:21],0}.
REQ-024 All arithmetic SHALL be 32-bit modulo 2^32; sub SHALL be SrcA + ~SrcB + 1; slt SHALL compare signed and give 32'h1 or 32'h0.
REQ-025 Adr, Result, Zero, op, funct3 and funct7b5 SHALL be purely combinational from the current state and inputs, with no added latency.
REQ-026 Latency: a value written into the PC or a register is visible on Adr or RD one edge after the write.
REQ-027 Simultaneous PCWrite and IRWrite SHALL load OldPC with the pre-edge PC, so OldPC holds the fetched instruction's address.

Reset
REQ-028 While reset=1, PC SHALL equal RESET_PC, and OldPC, Instr, Data, A, B, ALUOut and all 32 registers SHALL equal 0, regardless of clk.
REQ-029 With reset asserted and AdrSrc=0, Adr=RESET_PC, op=0, funct3=0, funct7b5=0 and WriteData=0.
REQ-030 Reset asserted mid-instruction SHALL discard all pending state; the first edge after deassertion obeys the control inputs.

Verification
REQ-031 Reset: assert reset with RESET_PC=0, AdrSrc=0 -> Adr=0x0, op=0000000, WriteData=0.
REQ-032 Fetch:
- Stimulus: ReadData=0x00500093, IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=10, ALUControl=000, ResultSrc=10; one edge.
- Response: PC=4, op=0010011, funct3=000, OldPC=0.
REQ-033 Addi execute and writeback:
- Execute: ALUSrcA=10, ALUSrcB=01, add -> ALUOut=5 after the edge.
- Writeback: ResultSrc=00, RegWrite=1 -> x1=5.
- Check: load Instr 0x00100023 (rs2=x1) -> WriteData=5 two edges later.
REQ-034 Immediate:
- Stimulus: Instr=0xFFF00093, A=0, ALUSrcA=10, ALUSrcB=01, add, ResultSrc=10, AdrSrc=1.
- Response: Adr=0xFFFFFFFF.
REQ-035 x0 write: RegWrite=1 with rd=0 and Result=0x1234 -> a subsequent read of x0 gives A=0.
REQ-036 ALU/Zero:
- A=B=7 with sub -> Zero=1.
- A=0xFFFFFFFF, B=1 with slt -> ALUResult=1.
- A=1, B=0xFFFFFFFF with slt -> ALUResult=0, Zero=1.
